// File: rtl/tcdm_banks_pkg.sv
// Shared types and limits for the banked TCDM wrapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tcdm_banks_pkg;

  // Controller states: IDLE is the post-reset holding state, INIT runs the zero-fill,
  // READY grants every bank.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } tcdm_state_e;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 3;
  localparam int unsigned BANK_SIZE_MIN  = 16;
  localparam int unsigned BANK_SIZE_MAX  = 4096;
  localparam int unsigned NB_BANKS_MIN   = 1;
  localparam int unsigned NB_BANKS_MAX   = 32;
  localparam int unsigned DATA_WIDTH_MIN = 32;
  localparam int unsigned DATA_WIDTH_MAX = 64;

  // Number of byte-offset bits below the word address for a given word width.
  function automatic int unsigned word_off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/tcdm_bank_sram.sv
// Single-port byte-enabled bank memory with a registered read port.
// Latency: read data valid one cycle after a read request; writes land at the same edge.
// Backpressure: none; every request is serviced in the cycle it is presented.
module tcdm_bank_sram #(
  parameter int unsigned WORDS      = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [$clog2(WORDS)-1:0]     addr_i,
  input  logic [DATA_WIDTH/8-1:0]      be_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read port: only a read updates the output register, so it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (req_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  // Read data register; no reset, contents are meaningless until the first read.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  // Byte-masked write; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tcdm_banks_pipe_wrap.sv
// Multi-bank TCDM with zero-fill controller and a configurable read pipeline.
// Latency: read response exactly RD_LATENCY cycles after acceptance; writes take effect next cycle.
// Backpressure: grants drop for all banks during the zero-fill; otherwise every request is accepted.
module tcdm_banks_pipe_wrap
  import tcdm_banks_pkg::*;
#(
  parameter int unsigned BANK_SIZE  = 256,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                test_mode_i,
  input  logic                                init_start_i,
  input  logic [NB_BANKS-1:0]                 req_i,
  output logic [NB_BANKS-1:0]                 gnt_o,
  input  logic [NB_BANKS-1:0]                 wen_i,
  input  logic [NB_BANKS*ADDR_WIDTH-1:0]      add_i,
  input  logic [NB_BANKS*(DATA_WIDTH/8)-1:0]  be_i,
  input  logic [NB_BANKS*DATA_WIDTH-1:0]      data_i,
  input  logic [NB_BANKS*ID_WIDTH-1:0]        id_i,
  output logic [NB_BANKS-1:0]                 r_valid_o,
  output logic [NB_BANKS*DATA_WIDTH-1:0]      r_data_o,
  output logic [NB_BANKS*ID_WIDTH-1:0]        r_id_o,
  output logic                                init_busy_o,
  output logic                                init_done_o
);

  localparam int unsigned AW   = $clog2(BANK_SIZE);
  localparam int unsigned OFF  = word_off_bits(DATA_WIDTH);
  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam logic [AW-1:0] CNT_LAST = AW'(BANK_SIZE - 1);

  tcdm_state_e   state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          init_done_d, init_done_q;
  logic          fill_active;

  // DFT mode has no functional effect on this block.
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Controller next state: fill sequencing, re-fill requests and the sticky done flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (INIT_ZERO != 0) ? INIT : READY;
      end
      INIT: begin
        // A further init_start_i is deliberately ignored while filling.
        if (cnt_q == CNT_LAST) begin
          state_d     = READY;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (init_start_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller registers; a reset during a fill restarts it from word 0 via IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign fill_active = (state_q == INIT);
  assign gnt_o       = {NB_BANKS{state_q == READY}};
  assign init_busy_o = fill_active;
  assign init_done_o = init_done_q;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [ADDR_WIDTH-1:0] add;
    logic                  unused_add;
    logic                  rd_acc;
    logic                  bank_req;
    logic                  bank_we;
    logic [AW-1:0]         bank_addr;
    logic [BE_W-1:0]       bank_be;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic [RD_LATENCY-1:0] vld_d, vld_q;
    logic [ID_WIDTH-1:0]   id_d [RD_LATENCY];
    logic [ID_WIDTH-1:0]   id_q [RD_LATENCY];

    // Only the word-index bits select a location; the rest alias.
    assign add        = add_i[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign unused_add = ^{add[ADDR_WIDTH-1:AW+OFF], add[OFF-1:0]};
    assign rd_acc     = req_i[b] & gnt_o[b] & wen_i[b];

    // Bank port mux: the zero-fill owns the port while active (grants are low then).
    always_comb begin
      bank_req   = req_i[b] & gnt_o[b];
      bank_we    = ~wen_i[b];
      bank_addr  = add[AW+OFF-1:OFF];
      bank_be    = be_i[b*BE_W +: BE_W];
      bank_wdata = data_i[b*DATA_WIDTH +: DATA_WIDTH];
      if (fill_active) begin
        bank_req   = 1'b1;
        bank_we    = 1'b1;
        bank_addr  = cnt_q;
        bank_be    = '1;
        bank_wdata = '0;
      end
    end

    tcdm_bank_sram #(
      .WORDS      (BANK_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
      .clk_i   (clk_i),
      .req_i   (bank_req),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .be_i    (bank_be),
      .wdata_i (bank_wdata),
      .rdata_o (sram_rdata)
    );

    // Valid/id shift: stage 0 lines up with the SRAM output, later stages with the data pipe.
    always_comb begin
      vld_d    = '0;
      id_d     = id_q;
      vld_d[0] = rd_acc;
      if (rd_acc) begin
        id_d[0] = id_i[b*ID_WIDTH +: ID_WIDTH];
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          id_d[s] = id_q[s-1];
        end
      end
    end

    // Valid and id stages are reset; ids hold between responses.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int s = 0; s < RD_LATENCY; s++) begin
          id_q[s] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        id_q  <= id_d;
      end
    end

    assign r_valid_o[b]                      = vld_q[RD_LATENCY-1];
    assign r_id_o[b*ID_WIDTH +: ID_WIDTH]    = id_q[RD_LATENCY-1];

    if (RD_LATENCY == 1) begin : g_lat1
      // The SRAM read register already holds its value between reads.
      assign r_data_o[b*DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
    end else begin : g_latn
      logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY-1];
      logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY-1];

      // Data stages advance only with a valid, so the output holds its last response.
      always_comb begin
        dat_d = dat_q;
        if (vld_q[0]) begin
          dat_d[0] = sram_rdata;
        end
        for (int s = 1; s < RD_LATENCY - 1; s++) begin
          if (vld_q[s]) begin
            dat_d[s] = dat_q[s-1];
          end
        end
      end

      // Data stages carry no reset; their validity comes from the valid pipe.
      always_ff @(posedge clk_i) begin
        dat_q <= dat_d;
      end

      assign r_data_o[b*DATA_WIDTH +: DATA_WIDTH] = dat_q[RD_LATENCY-2];
    end
  end

endmodule

// File: tb/tb_tcdm_banks_pipe_wrap.sv
// Directed bench for the banked TCDM wrapper (4 banks, 256 words, 32-bit, RD_LATENCY 2).
// Latency: checks response timing relative to request acceptance.
// Backpressure: checks grant behaviour around the zero-fill.
module tb_tcdm_banks_pipe_wrap;

  localparam int NB  = 4;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int LAT = 2;
  localparam int BS  = 256;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              test_mode_i;
  logic              init_start_i;
  logic [NB-1:0]     req_i;
  logic [NB-1:0]     gnt_o;
  logic [NB-1:0]     wen_i;
  logic [NB*32-1:0]  add_i;
  logic [NB*4-1:0]   be_i;
  logic [NB*DW-1:0]  data_i;
  logic [NB*IDW-1:0] id_i;
  logic [NB-1:0]     r_valid_o;
  logic [NB*DW-1:0]  r_data_o;
  logic [NB*IDW-1:0] r_id_o;
  logic              init_busy_o;
  logic              init_done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcdm_banks_pipe_wrap #(
    .BANK_SIZE  (BS),
    .NB_BANKS   (NB),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW),
    .RD_LATENCY (LAT),
    .INIT_ZERO  (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .test_mode_i  (test_mode_i),
    .init_start_i (init_start_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .wen_i        (wen_i),
    .add_i        (add_i),
    .be_i         (be_i),
    .data_i       (data_i),
    .id_i         (id_i),
    .r_valid_o    (r_valid_o),
    .r_data_o     (r_data_o),
    .r_id_o       (r_id_o),
    .init_busy_o  (init_busy_o),
    .init_done_o  (init_done_o)
  );

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int b, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_i[b]            = 1'b1;
    wen_i[b]            = 1'b0;
    add_i[b*32 +: 32]   = a;
    data_i[b*DW +: DW]  = d;
    be_i[b*4 +: 4]      = be;
    step();
    req_i[b] = 1'b0;
    wen_i[b] = 1'b1;
  endtask

  // Issue one read and wait (bounded) for its response; lat counts from the request cycle.
  task automatic do_read(input int b, input logic [31:0] a, input logic [3:0] id,
                         output int lat, output logic [31:0] dat, output logic [3:0] rid);
    req_i[b]             = 1'b1;
    wen_i[b]             = 1'b1;
    add_i[b*32 +: 32]    = a;
    id_i[b*IDW +: IDW]   = id;
    step();
    req_i[b] = 1'b0;
    lat = 1;
    while (!r_valid_o[b] && lat < 12) begin
      step();
      lat++;
    end
    dat = r_data_o[b*DW +: DW];
    rid = r_id_o[b*IDW +: IDW];
  endtask

  // Count cycles with init_busy_o high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (init_busy_o && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    rst_i = 1'b1;
    step();
    step();
    checks++; if (gnt_o !== 4'h0) begin failures++; $display("FAIL rst_gnt got=%h exp=0", gnt_o); end
    checks++; if (r_valid_o !== 4'h0) begin failures++; $display("FAIL rst_rvalid got=%h exp=0", r_valid_o); end
    checks++; if (r_id_o !== 16'h0) begin failures++; $display("FAIL rst_rid got=%h exp=0", r_id_o); end
    checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", init_done_o); end
    checks++; if (init_busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", init_busy_o); end
    rst_i = 1'b0;
    step();
    checks++; if (gnt_o !== 4'h0) begin failures++; $display("FAIL fill_gnt got=%h exp=0", gnt_o); end
    count_busy(n);
    checks++; if (n !== BS) begin failures++; $display("FAIL fill_cycles got=%0d exp=%0d", n, BS); end
    checks++; if (gnt_o !== 4'hF) begin failures++; $display("FAIL ready_gnt got=%h exp=f", gnt_o); end
    checks++; if (init_done_o !== 1'b1) begin failures++; $display("FAIL ready_done got=%b exp=1", init_done_o); end
  endtask

  task automatic test_fill_zero();
    int lat; logic [31:0] dat; logic [3:0] rid;
    do_read(0, 32'h0000_03FC, 4'h1, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL fill_rd_b0 got=%h exp=0", dat); end
    do_read(3, 32'h0000_0000, 4'h2, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL fill_rd_b3 got=%h exp=0", dat); end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] dat; logic [3:0] rid;
    write_word(2, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0101);
    checks++; if (r_valid_o !== 4'h0) begin failures++; $display("FAIL wr_no_rvalid got=%h exp=0", r_valid_o); end
    do_read(2, 32'h0000_0040, 4'h5, lat, dat, rid);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL bw_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (dat !== 32'h00AD_00EF) begin failures++; $display("FAIL bw_data got=%h exp=00ad00ef", dat); end
    checks++; if (rid !== 4'h5) begin failures++; $display("FAIL bw_id got=%h exp=5", rid); end
    step();
    checks++; if (r_valid_o[2] !== 1'b0) begin failures++; $display("FAIL bw_pulse got=%b exp=0", r_valid_o[2]); end
    checks++; if (r_data_o[64 +: 32] !== 32'h00AD_00EF) begin failures++; $display("FAIL bw_hold got=%h exp=00ad00ef", r_data_o[64 +: 32]); end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] dat; logic [3:0] rid;
    do_read(2, 32'h0001_0040, 4'h9, lat, dat, rid);
    checks++; if (dat !== 32'h00AD_00EF) begin failures++; $display("FAIL alias_rd got=%h exp=00ad00ef", dat); end
    checks++; if (rid !== 4'h9) begin failures++; $display("FAIL alias_id got=%h exp=9", rid); end
    write_word(1, 32'h0001_0040, 32'h1234_5678, 4'hF);
    do_read(1, 32'h0000_0040, 4'hA, lat, dat, rid);
    checks++; if (dat !== 32'h1234_5678) begin failures++; $display("FAIL alias_wr got=%h exp=12345678", dat); end
    do_read(0, 32'h0000_0040, 4'hB, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL bank_indep got=%h exp=0", dat); end
  endtask

  task automatic test_back_to_back();
    int pulses [NB];
    logic [31:0] exp_d;
    logic [3:0]  exp_id;
    test_mode_i = 1'b1;
    for (int b = 0; b < NB; b++) pulses[b] = 0;
    // Parallel writes to words 128..137 of every bank.
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < NB; b++) begin
        req_i[b]           = 1'b1;
        wen_i[b]           = 1'b0;
        add_i[b*32 +: 32]  = 32'h200 + 32'(i * 4);
        data_i[b*DW +: DW] = 32'hB000_0000 | 32'(b << 8) | 32'(i);
        be_i[b*4 +: 4]     = 4'hF;
      end
      step();
    end
    // Reads every cycle; read j is observed after the edge in iteration j+1.
    for (int k = 0; k < 13; k++) begin
      for (int b = 0; b < NB; b++) begin
        req_i[b] = (k < 10);
        wen_i[b] = 1'b1;
        add_i[b*32 +: 32]  = 32'h200 + 32'(k * 4);
        id_i[b*IDW +: IDW] = 4'((k * 3 + b) & 15);
      end
      step();
      for (int b = 0; b < NB; b++) begin
        if (k >= 1 && k <= 10) begin
          exp_d  = 32'hB000_0000 | 32'(b << 8) | 32'(k - 1);
          exp_id = 4'(((k - 1) * 3 + b) & 15);
          checks++; if (r_valid_o[b] !== 1'b1) begin failures++; $display("FAIL b2b_vld bank=%0d k=%0d got=0 exp=1", b, k); end
          checks++; if (r_id_o[b*IDW +: IDW] !== exp_id) begin failures++; $display("FAIL b2b_id bank=%0d k=%0d got=%h exp=%h", b, k, r_id_o[b*IDW +: IDW], exp_id); end
          checks++; if (r_data_o[b*DW +: DW] !== exp_d) begin failures++; $display("FAIL b2b_data bank=%0d k=%0d got=%h exp=%h", b, k, r_data_o[b*DW +: DW], exp_d); end
        end else begin
          checks++; if (r_valid_o[b] !== 1'b0) begin failures++; $display("FAIL b2b_idle bank=%0d k=%0d got=1 exp=0", b, k); end
        end
        if (r_valid_o[b]) pulses[b]++;
      end
    end
    for (int b = 0; b < NB; b++) begin
      checks++; if (pulses[b] !== 10) begin failures++; $display("FAIL b2b_count bank=%0d got=%0d exp=10", b, pulses[b]); end
    end
    req_i       = '0;
    test_mode_i = 1'b0;
  endtask

  task automatic test_init_race();
    int n; int got; int lat; logic [31:0] dat; logic [3:0] rid;
    write_word(0, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
    init_start_i       = 1'b1;
    req_i[0]           = 1'b1;
    wen_i[0]           = 1'b1;
    add_i[31:0]        = 32'h0000_0020;
    id_i[3:0]          = 4'h3;
    step();
    init_start_i = 1'b0;
    req_i[0]     = 1'b0;
    n   = 0;
    got = 0;
    while (gnt_o == 4'h0 && n < 1000) begin
      if (r_valid_o[0]) begin
        got++;
        checks++; if (r_data_o[31:0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL race_data got=%h exp=cafef00d", r_data_o[31:0]); end
        checks++; if (r_id_o[3:0] !== 4'h3) begin failures++; $display("FAIL race_id got=%h exp=3", r_id_o[3:0]); end
      end
      // A second start request mid-fill must not lengthen the fill.
      init_start_i = (n == 50);
      n++;
      step();
    end
    init_start_i = 1'b0;
    checks++; if (n !== BS) begin failures++; $display("FAIL race_gnt_low got=%0d exp=%0d", n, BS); end
    checks++; if (got !== 1) begin failures++; $display("FAIL race_resp got=%0d exp=1", got); end
    do_read(0, 32'h0000_0020, 4'h4, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL refill_b0 got=%h exp=0", dat); end
    do_read(2, 32'h0000_0040, 4'h6, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL refill_b2 got=%h exp=0", dat); end
  endtask

  task automatic test_reset_mid_init();
    int n; int lat; logic [31:0] dat; logic [3:0] rid;
    write_word(3, 32'h0000_0320, 32'h55AA_55AA, 4'hF);
    init_start_i = 1'b1;
    step();
    init_start_i = 1'b0;
    for (int i = 0; i < 100; i++) step();
    checks++; if (init_busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", init_busy_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++; if (gnt_o !== 4'h0) begin failures++; $display("FAIL mid_rst_gnt got=%h exp=0", gnt_o); end
    checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", init_done_o); end
    checks++; if (init_busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", init_busy_o); end
    step();
    count_busy(n);
    checks++; if (n !== BS) begin failures++; $display("FAIL mid_refill_cycles got=%0d exp=%0d", n, BS); end
    checks++; if (init_done_o !== 1'b1) begin failures++; $display("FAIL mid_done got=%b exp=1", init_done_o); end
    do_read(3, 32'h0000_0320, 4'h7, lat, dat, rid);
    checks++; if (dat !== 32'h0) begin failures++; $display("FAIL mid_word200 got=%h exp=0", dat); end
  endtask

  initial begin
    rst_i        = 1'b1;
    test_mode_i  = 1'b0;
    init_start_i = 1'b0;
    req_i        = '0;
    wen_i        = '1;
    add_i        = '0;
    be_i         = '0;
    data_i       = '0;
    id_i         = '0;
    test_reset();
    test_fill_zero();
    test_byte_write();
    test_alias();
    test_back_to_back();
    test_init_race();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcdm_banks_pipe_wrap.md
TCDM_BANKS_PIPE_WRAP -- requirements
Module: tcdm_banks_pipe_wrap

Interface
REQ-001 SHALL have parameter BANK_SIZE, default 256, words per bank; power of two, 16 to 4096.
REQ-002 SHALL have parameter NB_BANKS, default 4, number of independent banks; 1 to 32.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width in bits; 32 or 64.
REQ-004 SHALL have parameter ID_WIDTH, default 4, request tag width.
REQ-005 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; 1 to 3.
REQ-006 SHALL have parameter INIT_ZERO, default 1; when 1, the banks are zero-filled after reset.
REQ-007 SHALL have ports as follows; one clock, and the reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- test_mode_i  in  1  DFT mode; no functional effect
- init_start_i  in  1  pulse; requests a zero-fill
- req_i  in  NB_BANKS  per-bank request
- gnt_o  out  NB_BANKS  per-bank grant
- wen_i  in  NB_BANKS  1 = read, 0 = write
- add_i  in  NB_BANKS x 32  byte address
- be_i  in  NB_BANKS x DATA_WIDTH/8  byte enables, active-high
- data_i  in  NB_BANKS x DATA_WIDTH  write data
- id_i  in  NB_BANKS x ID_WIDTH  request tag
- r_valid_o  out  NB_BANKS  read data valid
- r_data_o  out  NB_BANKS x DATA_WIDTH  read data
- r_id_o  out  NB_BANKS x ID_WIDTH  returned tag
- init_busy_o  out  1  zero-fill in progress
- init_done_o  out  1  at least one zero-fill has completed since reset

Function
REQ-008 SHALL form the word address as add_i[log2(BANK_SIZE)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; all other address bits are ignored.
REQ-009 SHALL use a single controller FSM with states IDLE, INIT and READY.
- After reset: INIT if INIT_ZERO = 1, otherwise READY.
- INIT to READY after word BANK_SIZE-1 is written.
- READY to INIT on init_start_i = 1.
- init_start_i is ignored while in INIT.
REQ-010 SHALL, in INIT, write zero with all byte enables set to word address cnt in every bank in the same cycle; cnt starts at 0, increments by 1 per cycle, and takes exactly BANK_SIZE cycles.
REQ-011 SHALL drive gnt_o = 0 in INIT and IDLE, and gnt_o = all ones in READY; a request is accepted only when req_i & gnt_o.
REQ-012 SHALL, on an accepted write, update only the enabled bytes; the result is visible to a read accepted on the next cycle.
REQ-013 SHALL, on an accepted read, assert r_valid_o exactly RD_LATENCY cycles later for one cycle, with r_data_o and r_id_o aligned to it; back-to-back reads give back-to-back responses.
REQ-014 SHALL produce no r_valid_o for writes.
REQ-015 SHALL hold r_data_o at its last value when r_valid_o = 0.
REQ-016 SHALL let reads accepted before an INIT entry complete normally, returning the pre-fill data.
REQ-017 SHALL keep all banks independent, with no cross-bank arbitration.
REQ-018 SHALL assert init_busy_o exactly while in INIT; init_done_o rises on the first INIT to READY transition and stays 1 until reset.

Reset
REQ-019 SHALL, on rst_i = 1 at a clock edge, clear the FSM, cnt, every r_valid_o pipeline stage, r_id_o and init_done_o.
REQ-020 SHALL make gnt_o = 0 and r_valid_o = 0 in the cycle after reset is sampled.
REQ-021 SHALL NOT require memory contents to be reset; contents are undefined when INIT_ZERO = 0.
REQ-022 SHALL, on reset during INIT, restart the fill from word 0.

Structure
REQ-023 SHALL place the FSM state typedef and the latency and width limit constants in package tcdm_banks_pkg.
REQ-024 SHALL use one sub-module, tcdm_bank_sram: a one-cycle, byte-enabled, single-port memory instantiated NB_BANKS times.
REQ-025 SHALL realise the RD_LATENCY-1 extra cycles as a per-bank register pipeline carrying valid, data and id.

Verification
REQ-026 Reset release with INIT_ZERO = 1 and BANK_SIZE = 256 -> init_busy_o high for exactly 256 cycles, then gnt_o = 4'hF and init_done_o = 1; a read of any word returns 0.
REQ-027 Bank 2 writes 32'hDEADBEEF to 0x40 with be = 4'b0101, then reads 0x40 with id 5 -> with RD_LATENCY = 2, r_valid_o[2] fires 2 cycles later, r_data = 32'h00AD00EF, r_id = 5.
REQ-028 All 4 banks issue reads every cycle for 10 cycles -> 10 consecutive r_valid_o pulses per bank, each carrying the id of its own request.
REQ-029 Read accepted in the same cycle that init_start_i is pulsed -> the read returns the old data, and gnt_o falls the next cycle for 256 cycles.
REQ-030 rst_i asserted at cnt = 100 during INIT -> after release, the fill restarts at word 0 and the full 256-cycle fill runs.
REQ-031 Address 0x1_0040 with BANK_SIZE = 256 -> aliases to word 0x10, the same word as address 0x40.
